// File: rtl/fp32_align_stage_pkg.sv
// Shared FP32 definitions for the align / add / normalise stages.
// Pure declarations: no latency.
// No flow control lives here.
package fp32_align_stage_pkg;

    // IEEE-754 single field positions
    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int FRAC_HI  = 22;

    localparam logic [7:0] EXP_MAX   = 8'hFF;
    localparam int         MAN_W_DEF = 27;

    // FSM encoding shared with the adder and normaliser stages
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // {hidden, fraction, GRS=000}; exponent 0 is treated as zero (no denormals)
    function automatic logic [MAN_W_DEF-1:0] expand_sig(input logic [31:0] op);
        logic [MAN_W_DEF-1:0] s;
        if (op[EXP_HI:EXP_LO] != 8'd0) begin
            s = {1'b1, op[FRAC_HI:0], 3'b000};
        end else begin
            s = '0;
        end
        return s;
    endfunction

endpackage

// File: rtl/fp32_align_stage_if.sv
// Request/result bundle between the issuing logic and the align stage.
// No latency of its own.
// Results are held while ready is high until the next accepted start.
interface fp32_align_stage_if #(
    parameter int MAN_W = 27
);
    logic             en;
    logic             start;
    logic             PlusOrMinus;
    logic [31:0]      A;
    logic [31:0]      B;
    logic [MAN_W-1:0] manLarge;
    logic [MAN_W-1:0] manSmall;
    logic [7:0]       expOut;
    logic             signOut;
    logic             effSub;
    logic             exc;
    logic             ready;

    modport master (
        output en, start, PlusOrMinus, A, B,
        input  manLarge, manSmall, expOut, signOut, effSub, exc, ready
    );

    modport slave (
        input  en, start, PlusOrMinus, A, B,
        output manLarge, manSmall, expOut, signOut, effSub, exc, ready
    );
endinterface

// File: rtl/fp_sticky_shifter.sv
// Significand register: load, shift right by one with sticky OR, one-cycle flush.
// Each operation takes effect on the next rising edge.
// No backpressure; the caller gates the controls with its clock enable.
module fp_sticky_shifter #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    // Next value: load wins over flush, flush over shift; bit 0 is the sticky bit
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = din_i;
        end else if (flush_i) begin
            sig_d    = '0;
            sig_d[0] = |din_i;
        end else if (shift_i) begin
            sig_d = {1'b0, sig_q[W-1:2], sig_q[1] | sig_q[0]};
        end
    end

    // Significand register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign q_o = sig_q;

endmodule

// File: rtl/fp32_align_stage.sv
// Orders two FP32 operands by magnitude and right-aligns the smaller significand.
// Latency 1+d enabled cycles (1 for d=0, flush or Inf/NaN), at most 27.
// en low freezes everything; start is only honoured in IDLE or DONE.
module fp32_align_stage
    import fp32_align_stage_pkg::*;
#(
    parameter int MAN_W   = MAN_W_DEF,
    parameter int FLUSH_D = 27
) (
    input logic               clk,
    input logic               rst,
    fp32_align_stage_if.slave bus
);

    localparam int CNT_W = 5;

    state_t           state_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             b_sign_q;
    logic [CNT_W-1:0] cnt_q;
    logic [MAN_W-1:0] man_large_q;
    logic [7:0]       exp_q;
    logic             sign_q;
    logic             eff_sub_q;
    logic             exc_q;
    logic             ready_q;

    logic             a_ge;
    logic             is_exc;
    logic             flush_c;
    logic [7:0]       exp_l;
    logic [7:0]       exp_s;
    logic [7:0]       diff;
    logic [MAN_W-1:0] sig_a;
    logic [MAN_W-1:0] sig_b;
    logic [MAN_W-1:0] sig_l;
    logic [MAN_W-1:0] sig_s;
    logic             sh_load;
    logic             sh_flush;
    logic             sh_shift;
    logic [MAN_W-1:0] man_small;

    // Magnitude compare on {exp,frac}; ties pick A as the larger operand
    always_comb begin
        sig_a   = expand_sig(a_q);
        sig_b   = expand_sig(b_q);
        a_ge    = a_q[EXP_HI:0] >= b_q[EXP_HI:0];
        exp_l   = a_ge ? a_q[EXP_HI:EXP_LO] : b_q[EXP_HI:EXP_LO];
        exp_s   = a_ge ? b_q[EXP_HI:EXP_LO] : a_q[EXP_HI:EXP_LO];
        sig_l   = a_ge ? sig_a : sig_b;
        sig_s   = a_ge ? sig_b : sig_a;
        diff    = exp_l - exp_s;
        flush_c = int'(diff) >= FLUSH_D;
        is_exc  = (a_q[EXP_HI:EXP_LO] == EXP_MAX) || (b_q[EXP_HI:EXP_LO] == EXP_MAX);
    end

    // Shifter controls follow the FSM state, gated by the clock enable
    always_comb begin
        sh_load  = bus.en && (state_q == ST_COMPARE) && !flush_c;
        sh_flush = bus.en && (state_q == ST_COMPARE) && flush_c;
        sh_shift = bus.en && (state_q == ST_SHIFT);
    end

    fp_sticky_shifter #(
        .W (MAN_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .flush_i (sh_flush),
        .shift_i (sh_shift),
        .din_i   (sig_s),
        .q_o     (man_small)
    );

    // Control FSM with registered outputs; every update is gated by en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            b_sign_q    <= 1'b0;
            cnt_q       <= '0;
            man_large_q <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exc_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else if (bus.en) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        // Subtraction is folded into B's sign up front
                        b_sign_q <= bus.B[SIGN_BIT] ^ bus.PlusOrMinus;
                        ready_q  <= 1'b0;
                        state_q  <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    man_large_q <= sig_l;
                    exp_q       <= exp_l;
                    sign_q      <= a_ge ? a_q[SIGN_BIT] : b_sign_q;
                    eff_sub_q   <= a_q[SIGN_BIT] ^ b_sign_q;
                    exc_q       <= is_exc;
                    if (is_exc || (diff == 8'd0) || flush_c) begin
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= diff[CNT_W-1:0];
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.manLarge = man_large_q;
    assign bus.manSmall = man_small;
    assign bus.expOut   = exp_q;
    assign bus.signOut  = sign_q;
    assign bus.effSub   = eff_sub_q;
    assign bus.exc      = exc_q;
    assign bus.ready    = ready_q;

endmodule

// File: tb/tb_fp32_align_stage.sv
// Scoreboard bench for fp32_align_stage: model results queued at issue, compared at ready.
// Latency measured in edges after the start-sampling edge.
// Exercises en stalls, reset mid-shift, flush, Inf and back-to-back operation.
module tb_fp32_align_stage;

    logic clk;
    logic rst;

    fp32_align_stage_if #(.MAN_W(27)) bus ();

    fp32_align_stage #(
        .MAN_W   (27),
        .FLUSH_D (27)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] ml;
        logic [26:0] ms;
        logic [7:0]  e;
        logic        s;
        logic        es;
        logic        x;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: barrel shift with sticky over the bits shifted out
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic pm);
        exp_t        m;
        logic [26:0] sa;
        logic [26:0] sbg;
        logic [26:0] ss;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [7:0]  d;
        logic        age;
        ea   = a[30:23];
        eb   = b[30:23];
        sa   = (ea != 8'd0) ? {1'b1, a[22:0], 3'b000} : 27'd0;
        sbg  = (eb != 8'd0) ? {1'b1, b[22:0], 3'b000} : 27'd0;
        age  = a[30:0] >= b[30:0];
        m.x  = (ea == 8'hFF) || (eb == 8'hFF);
        m.es = a[31] ^ b[31] ^ pm;
        m.s  = age ? a[31] : (b[31] ^ pm);
        m.e  = age ? ea : eb;
        m.ml = age ? sa : sbg;
        ss   = age ? sbg : sa;
        d    = age ? (ea - eb) : (eb - ea);
        if (d >= 8'd27) begin
            m.ms = {26'd0, |ss};
        end else begin
            m.ms = (ss >> d) | {26'd0, |(ss & ((27'd1 << d) - 27'd1))};
        end
        m.lat = (m.x || d == 8'd0 || d >= 8'd27) ? 1 : 1 + int'(d);
        return m;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic pm,
                          input int stall_at, input int stall_len);
        exp_t e;
        exp_t g;
        int   lat;
        e = model(a, b, pm);
        e.lat += stall_len;
        sb.push_back(e);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.A           = a;
        bus.B           = b;
        bus.PlusOrMinus = pm;
        lat = -1;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) lat = i;
            if (i == 0) bus.start = 1'b0;
            if (stall_len > 0 && i == stall_at) bus.en = 1'b0;
            if (stall_len > 0 && i == stall_at + stall_len) bus.en = 1'b1;
        end
        bus.en = 1'b1;
        g = sb.pop_front();
        chk("latency", 32'(lat), 32'(g.lat));
        chk("exc", {31'd0, bus.exc}, {31'd0, g.x});
        chk("signOut", {31'd0, bus.signOut}, {31'd0, g.s});
        if (!g.x) begin
            chk("manLarge", {5'd0, bus.manLarge}, {5'd0, g.ml});
            chk("manSmall", {5'd0, bus.manSmall}, {5'd0, g.ms});
            chk("expOut", {24'd0, bus.expOut}, {24'd0, g.e});
            chk("effSub", {31'd0, bus.effSub}, {31'd0, g.es});
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [7:0]  re;
        n_vec           = 0;
        n_err           = 0;
        rst             = 1'b1;
        bus.en          = 1'b1;
        bus.start       = 1'b0;
        bus.PlusOrMinus = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_manLarge", {5'd0, bus.manLarge}, 32'd0);
        chk("rst_manSmall", {5'd0, bus.manSmall}, 32'd0);
        chk("rst_expOut", {24'd0, bus.expOut}, 32'd0);
        rst = 1'b0;

        // 6.75 + 3: d=1
        run_op(32'h40D80000, 32'h40400000, 1'b0, 0, 0);
        chk("t1_manLarge_abs", {5'd0, bus.manLarge}, 32'h06C00000);
        chk("t1_manSmall_abs", {5'd0, bus.manSmall}, 32'h03000000);
        run_op(32'h40D80000, 32'h40400000, 1'b1, 0, 0);
        run_op(32'hC0D80000, 32'h40400000, 1'b0, 0, 0);
        // equal operands, subtract: d=0
        run_op(32'h40400000, 32'h40400000, 1'b1, 0, 0);
        // 1.0 and 2^-30: flush
        run_op(32'h3F800000, 32'h30800000, 1'b0, 0, 0);
        chk("flush_manSmall_abs", {5'd0, bus.manSmall}, 32'h00000001);
        // 1.0 and 1.5*2^-4: d=4, en low for three edges mid-shift
        run_op(32'h3F800000, 32'h3DC00000, 1'b0, 2, 3);
        chk("stall_manSmall_abs", {5'd0, bus.manSmall}, 32'h00600000);
        // B = +Inf
        run_op(32'h3F800000, 32'h7F800000, 1'b0, 0, 0);

        // reset two cycles into a d=20 shift
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'h3F800000;
        bus.B     = 32'h35800000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
        chk("midrst_manLarge", {5'd0, bus.manLarge}, 32'd0);
        chk("midrst_manSmall", {5'd0, bus.manSmall}, 32'd0);
        chk("midrst_expOut", {24'd0, bus.expOut}, 32'd0);
        chk("midrst_flags", {29'd0, bus.signOut, bus.effSub, bus.exc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h3F800000, 32'h35800000, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("ready_hold", {31'd0, bus.ready}, 32'd1);

        // random operands with exponents near each other
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = $urandom;
            re = ra[30:23] - 8'($urandom_range(0, 28));
            rb[30:23] = re;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
